// File: rtl/wb_interconnect_pkg.sv
// Shared Wishbone definitions for the interconnect slice.
//   - WISHBONE_SLICE: picks port `idx` of width `w` out of a flat-packed bus.
//   - Default bus widths, arbiter state encoding and the byte-select width helper.
// No ports; imported by wb_rr_arbiter and wb_interconnect.
`ifndef WISHBONE_SLICE
`define WISHBONE_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package wb_pkg;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_TAG_WIDTH  = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  function automatic int wb_sel_width(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/wb_interconnect_if.sv
// Flat-packed Wishbone bus bundle for the shared-bus interconnect.
// Master side: master_cyc/stb/we/tag/sel/adr/mosi requests, master_miso/ack/err responses.
// Slave side:  slave_cyc/stb/we/tag/sel/adr/mosi requests, slave_miso/ack/err responses.
// Port i of any bus is slice i. Modports:
//   ic     - the interconnect itself
//   master - agents that issue requests
//   slave  - agents that answer requests
interface wb_interconnect_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 4,
  parameter int MASTER_COUNT = 2,
  parameter int SLAVE_COUNT  = 2
);
  localparam int SEL_W = DATA_WIDTH / 8;

  logic [MASTER_COUNT-1:0]            master_cyc;
  logic [MASTER_COUNT-1:0]            master_stb;
  logic [MASTER_COUNT-1:0]            master_we;
  logic [MASTER_COUNT*TAG_WIDTH-1:0]  master_tag;
  logic [MASTER_COUNT*SEL_W-1:0]      master_sel;
  logic [MASTER_COUNT*ADDR_WIDTH-1:0] master_adr;
  logic [MASTER_COUNT*DATA_WIDTH-1:0] master_mosi;
  logic [MASTER_COUNT*DATA_WIDTH-1:0] master_miso;
  logic [MASTER_COUNT-1:0]            master_ack;
  logic [MASTER_COUNT-1:0]            master_err;

  logic [SLAVE_COUNT-1:0]             slave_cyc;
  logic [SLAVE_COUNT-1:0]             slave_stb;
  logic [SLAVE_COUNT-1:0]             slave_we;
  logic [SLAVE_COUNT*TAG_WIDTH-1:0]   slave_tag;
  logic [SLAVE_COUNT*SEL_W-1:0]       slave_sel;
  logic [SLAVE_COUNT*ADDR_WIDTH-1:0]  slave_adr;
  logic [SLAVE_COUNT*DATA_WIDTH-1:0]  slave_mosi;
  logic [SLAVE_COUNT*DATA_WIDTH-1:0]  slave_miso;
  logic [SLAVE_COUNT-1:0]             slave_ack;
  logic [SLAVE_COUNT-1:0]             slave_err;

  modport ic (
    input  master_cyc, master_stb, master_we, master_tag, master_sel, master_adr, master_mosi,
    output master_miso, master_ack, master_err,
    output slave_cyc, slave_stb, slave_we, slave_tag, slave_sel, slave_adr, slave_mosi,
    input  slave_miso, slave_ack, slave_err
  );

  modport master (
    output master_cyc, master_stb, master_we, master_tag, master_sel, master_adr, master_mosi,
    input  master_miso, master_ack, master_err
  );

  modport slave (
    input  slave_cyc, slave_stb, slave_we, slave_tag, slave_sel, slave_adr, slave_mosi,
    output slave_miso, slave_ack, slave_err
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin arbiter.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_req       per-master request (master_cyc)
//   o_grant     registered one-hot grant
//   o_grant_vld grant valid
// When idle, the first requester at or after the pointer wins and the pointer moves
// to winner+1. The grant is held while the owner keeps requesting and clears one edge
// after it drops, so consecutive owners are separated by one idle cycle.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int MASTER_COUNT = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [MASTER_COUNT-1:0] i_req,
  output logic [MASTER_COUNT-1:0] o_grant,
  output logic                    o_grant_vld
);
  localparam int PW = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;

  arb_state_e              r_state;
  logic [MASTER_COUNT-1:0] r_grant;
  logic [PW-1:0]           r_ptr;
  logic [MASTER_COUNT-1:0] w_pick;
  logic [PW-1:0]           w_ptr_nxt;

  // Two descending passes: the first finds the lowest requester overall (wrap case),
  // the second overrides it with the lowest requester at or after the pointer.
  always_comb begin
    w_pick    = '0;
    w_ptr_nxt = r_ptr;
    for (int m = MASTER_COUNT - 1; m >= 0; m--) begin
      if (i_req[m]) begin
        w_pick    = '0;
        w_pick[m] = 1'b1;
        w_ptr_nxt = PW'((m + 1) % MASTER_COUNT);
      end
    end
    for (int m = MASTER_COUNT - 1; m >= 0; m--) begin
      if (i_req[m] && (m >= int'(r_ptr))) begin
        w_pick    = '0;
        w_pick[m] = 1'b1;
        w_ptr_nxt = PW'((m + 1) % MASTER_COUNT);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|i_req) begin
            r_state <= ARB_OWNED;
            r_grant <= w_pick;
            r_ptr   <= w_ptr_nxt;
          end
        end
        ARB_OWNED: begin
          if (~|(i_req & r_grant)) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
          end
        end
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_grant_vld = (r_state == ARB_OWNED);
endmodule

// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone interconnect: MASTER_COUNT masters, SLAVE_COUNT slaves.
// Ports:
//   sys_clk    clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        wb_interconnect_if.ic, all master- and slave-side Wishbone signals
// One master owns the bus (round-robin arbiter). The owner's address is decoded
// against per-slave base/mask pairs; the lowest matching slave index wins. Request
// fields are broadcast to every slave, but only the hit slave sees cyc/stb. The hit
// slave's response is routed back to the owner combinationally. An address that
// matches no slave gets a one-cycle error from an internal responder.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 4,
  parameter int MASTER_COUNT = 2,
  parameter int SLAVE_COUNT  = 2,
  parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  wb_interconnect_if.ic    bus
);
  localparam int SW = wb_sel_width(DATA_WIDTH);

  logic [MASTER_COUNT-1:0] w_grant;
  logic                    w_grant_vld;

  logic                    w_own_cyc;
  logic                    w_own_stb;
  logic                    w_own_we;
  logic [TAG_WIDTH-1:0]    w_own_tag;
  logic [SW-1:0]           w_own_sel;
  logic [ADDR_WIDTH-1:0]   w_own_adr;
  logic [DATA_WIDTH-1:0]   w_own_mosi;

  logic [SLAVE_COUNT-1:0]  w_hit_sel;
  logic                    w_hit_any;

  logic [DATA_WIDTH-1:0]   w_rsp_miso;
  logic                    w_rsp_ack;
  logic                    w_rsp_err;

  logic                    w_unmap_req;
  logic                    r_unmap_err;
  logic                    r_unmap_done;

  wb_rr_arbiter #(
    .MASTER_COUNT(MASTER_COUNT)
  ) u_arb (
    .i_clk       (sys_clk),
    .i_rst_n     (sys_rst_n),
    .i_req       (bus.master_cyc),
    .o_grant     (w_grant),
    .o_grant_vld (w_grant_vld)
  );

  // Owner request mux; everything reads as zero when nobody holds the grant.
  always_comb begin
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    w_own_we   = 1'b0;
    w_own_tag  = '0;
    w_own_sel  = '0;
    w_own_adr  = '0;
    w_own_mosi = '0;
    for (int m = 0; m < MASTER_COUNT; m++) begin
      if (w_grant_vld && w_grant[m]) begin
        w_own_cyc  = bus.master_cyc[m];
        w_own_stb  = bus.master_cyc[m] & bus.master_stb[m];
        w_own_we   = bus.master_we[m];
        w_own_tag  = `WISHBONE_SLICE(bus.master_tag, m, TAG_WIDTH);
        w_own_sel  = `WISHBONE_SLICE(bus.master_sel, m, SW);
        w_own_adr  = `WISHBONE_SLICE(bus.master_adr, m, ADDR_WIDTH);
        w_own_mosi = `WISHBONE_SLICE(bus.master_mosi, m, DATA_WIDTH);
      end
    end
  end

  // Address decode; descending scan so the lowest matching index is left standing.
  always_comb begin
    w_hit_sel = '0;
    w_hit_any = 1'b0;
    for (int s = SLAVE_COUNT - 1; s >= 0; s--) begin
      if ((w_own_adr & ~`WISHBONE_SLICE(SLAVE_MASK, s, ADDR_WIDTH)) ==
          (`WISHBONE_SLICE(SLAVE_ADDR, s, ADDR_WIDTH) & ~`WISHBONE_SLICE(SLAVE_MASK, s, ADDR_WIDTH))) begin
        w_hit_sel    = '0;
        w_hit_sel[s] = 1'b1;
        w_hit_any    = 1'b1;
      end
    end
  end

  assign bus.slave_cyc  = w_hit_sel & {SLAVE_COUNT{w_own_cyc}};
  assign bus.slave_stb  = w_hit_sel & {SLAVE_COUNT{w_own_stb}};
  assign bus.slave_we   = {SLAVE_COUNT{w_own_we}};
  assign bus.slave_tag  = {SLAVE_COUNT{w_own_tag}};
  assign bus.slave_sel  = {SLAVE_COUNT{w_own_sel}};
  assign bus.slave_adr  = {SLAVE_COUNT{w_own_adr}};
  assign bus.slave_mosi = {SLAVE_COUNT{w_own_mosi}};

  // Response mux from the hit slave, only while the owner's cycle is open.
  always_comb begin
    w_rsp_miso = '0;
    w_rsp_ack  = 1'b0;
    w_rsp_err  = 1'b0;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      if (w_own_cyc && w_hit_sel[s]) begin
        w_rsp_miso = `WISHBONE_SLICE(bus.slave_miso, s, DATA_WIDTH);
        w_rsp_ack  = bus.slave_ack[s];
        w_rsp_err  = bus.slave_err[s];
      end
    end
  end

  // Unmapped responder: err pulses the cycle after stb; r_unmap_done suppresses a
  // second pulse until the owner lowers stb (or the address becomes mapped).
  assign w_unmap_req = w_own_stb & ~w_hit_any;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_unmap_err  <= 1'b0;
      r_unmap_done <= 1'b0;
    end else begin
      r_unmap_err  <= w_unmap_req & ~r_unmap_err & ~r_unmap_done;
      r_unmap_done <= w_unmap_req & (r_unmap_err | r_unmap_done);
    end
  end

  always_comb begin
    bus.master_miso = '0;
    bus.master_ack  = '0;
    bus.master_err  = '0;
    for (int m = 0; m < MASTER_COUNT; m++) begin
      if (w_grant_vld && w_grant[m]) begin
        `WISHBONE_SLICE(bus.master_miso, m, DATA_WIDTH) = w_rsp_miso;
        bus.master_ack[m] = w_rsp_ack;
        bus.master_err[m] = w_rsp_err | r_unmap_err;
      end
    end
  end
endmodule

// File: tb/tb_wb_interconnect.sv
module tb_wb_interconnect;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_interconnect_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(4), .MASTER_COUNT(2), .SLAVE_COUNT(2)
  ) bus ();

  wb_interconnect #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .TAG_WIDTH    (4),
    .MASTER_COUNT (2),
    .SLAVE_COUNT  (2),
    .SLAVE_ADDR   ({32'h0000_0000, 32'h0000_4000}),
    .SLAVE_MASK   ({32'h0000_3FFF, 32'h0000_3FFF})
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    bus.master_cyc[m]           = cyc;
    bus.master_stb[m]           = stb;
    bus.master_we[m]            = we;
    bus.master_adr[m*32 +: 32]  = adr;
    bus.master_sel[m*4 +: 4]    = sel;
    bus.master_mosi[m*32 +: 32] = dat;
    bus.master_tag[m*4 +: 4]    = 4'h0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.master_cyc = '0; bus.master_stb = '0; bus.master_we = '0; bus.master_tag = '0;
    bus.master_sel = '0; bus.master_adr = '0; bus.master_mosi = '0;
    bus.slave_miso = '0; bus.slave_ack = '0; bus.slave_err = '0;
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset held with both masters requesting
    tick();
    chk("rst_slave_cyc", bus.slave_cyc, 2'b00);
    chk("rst_master_ack", bus.master_ack, 2'b00);
    chk("rst_master_err", bus.master_err, 2'b00);
    tick();
    chk("rst_master_miso", bus.master_miso, 64'h0);
    chk("rst_slave_adr", bus.slave_adr, 64'h0);

    // Release; master0 reads 0x4004 (slave0 window)
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_4004, 4'hF, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("pre_grant_slave_cyc", bus.slave_cyc, 2'b00);
    tick();
    chk("dec_slave_cyc", bus.slave_cyc, 2'b01);
    chk("dec_slave_stb", bus.slave_stb, 2'b01);
    chk("dec_slave_adr", bus.slave_adr, {32'h0000_4004, 32'h0000_4004});
    chk("dec_ack_before", bus.master_ack, 2'b00);
    bus.slave_ack  = 2'b01;
    bus.slave_miso = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    #1;
    chk("dec_master_ack", bus.master_ack, 2'b01);
    chk("dec_master_miso", bus.master_miso, {32'h0, 32'hDEAD_BEEF});
    chk("dec_master_err", bus.master_err, 2'b00);

    // Master0 releases; master1 queues a write to 0x0010 (slave1)
    bus.slave_ack = 2'b00;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678);
    #1;
    chk("rel_slave_cyc_same_cycle", bus.slave_cyc, 2'b00);
    tick();
    chk("idle_slave_cyc", bus.slave_cyc, 2'b00);
    chk("idle_slave_we", bus.slave_we, 2'b00);
    chk("idle_slave_mosi", bus.slave_mosi, 64'h0);
    tick();
    chk("wr_slave_cyc", bus.slave_cyc, 2'b10);
    chk("wr_slave_stb", bus.slave_stb, 2'b10);
    chk("wr_slave_we", bus.slave_we, 2'b11);
    chk("wr_slave_sel", bus.slave_sel, 8'b0011_0011);
    chk("wr_slave_mosi", bus.slave_mosi, {32'h1234_5678, 32'h1234_5678});
    chk("wr_slave_adr", bus.slave_adr, {32'h0000_0010, 32'h0000_0010});
    bus.slave_ack  = 2'b10;
    bus.slave_miso = {32'hA5A5_A5A5, 32'h0};
    #1;
    chk("wr_master_ack", bus.master_ack, 2'b10);
    chk("wr_master_miso", bus.master_miso, {32'hA5A5_A5A5, 32'h0});
    bus.slave_ack = 2'b00;
    bus.slave_err = 2'b10;
    #1;
    chk("slverr_master_err", bus.master_err, 2'b10);
    chk("slverr_master_ack", bus.master_ack, 2'b00);
    bus.slave_err = 2'b00;

    // Round-robin: ownership 0,1,0 with an idle cycle between owners
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("rr_idle0", bus.slave_cyc, 2'b00);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
    tick();
    chk("rr_own0_adr", bus.slave_adr, {32'h0000_0010, 32'h0000_0010});
    bus.slave_ack = 2'b10;
    #1;
    chk("rr_own0_ack", bus.master_ack, 2'b01);
    bus.slave_ack = 2'b00;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    tick();
    chk("rr_idle1_cyc", bus.slave_cyc, 2'b00);
    bus.slave_ack = 2'b10;
    #1;
    chk("rr_idle1_ack", bus.master_ack, 2'b00);
    bus.slave_ack = 2'b00;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    tick();
    chk("rr_own1_adr", bus.slave_adr, {32'h0000_0020, 32'h0000_0020});
    bus.slave_ack = 2'b10;
    #1;
    chk("rr_own1_ack", bus.master_ack, 2'b10);
    bus.slave_ack = 2'b00;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("rr_idle2_cyc", bus.slave_cyc, 2'b00);
    tick();
    chk("rr_own0b_cyc", bus.slave_cyc, 2'b10);
    chk("rr_own0b_adr", bus.slave_adr, {32'h0000_0010, 32'h0000_0010});

    // Unmapped address 0x8000
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_8000, 4'hF, 32'h0);
    tick();
    chk("unmap_slave_cyc0", bus.slave_cyc, 2'b00);
    chk("unmap_err0", bus.master_err, 2'b00);
    tick();
    chk("unmap_err1", bus.master_err, 2'b01);
    chk("unmap_ack1", bus.master_ack, 2'b00);
    chk("unmap_miso1", bus.master_miso, 64'h0);
    chk("unmap_slave_cyc1", bus.slave_cyc, 2'b00);
    tick();
    chk("unmap_err2", bus.master_err, 2'b00);
    tick();
    chk("unmap_err3", bus.master_err, 2'b00);

    // Reset in the middle of a slave0 transfer
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_4004, 4'hF, 32'h0);
    #1;
    chk("mid_slave_cyc", bus.slave_cyc, 2'b01);
    bus.slave_ack = 2'b01;
    #1;
    chk("mid_master_ack", bus.master_ack, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_slave_cyc", bus.slave_cyc, 2'b00);
    chk("mid_rst_master_ack", bus.master_ack, 2'b00);
    chk("mid_rst_slave_adr", bus.slave_adr, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
